// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter.
// A frame is sent MSB-first, one bit per clock, in this order: the sync pattern, the payload,
// and an even-parity bit over the payload. After the frame comes an idle gap of at least
// IDLE_BITS cycles.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (0 resets, 1 runs)
//   start_i      frame request, only taken when ready_o is high
//   din_i        payload, sampled only when a start is accepted
//   ready_o      high when a start will be accepted
//   out_o        serial bit stream
//   out_valid_o  high while out_o carries a frame bit (sync, data or parity)
//   done_o       one-cycle pulse on the parity-bit cycle
//
// All outputs are registered. Payload bits that recreate SYNC_PAT are not escaped.
module seq_frame_tx #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1011,
  parameter int unsigned       IDLE_BITS = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              ready_o,
  output logic              out_o,
  output logic              out_valid_o,
  output logic              done_o
);

  localparam int unsigned MaxSd  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MaxCnt = (MaxSd > IDLE_BITS) ? MaxSd : IDLE_BITS;
  // The counter only ever holds 0..N-1, so clog2(N) bits are enough.
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StPar,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic              par_q, par_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  // Outputs are computed for the state being entered, so each bit is registered at the edge
  // that starts its cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sync_d  = sync_q;
    par_d   = par_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (start_i) begin
          state_d = StSync;
          cnt_d   = '0;
          shreg_d = din_i;
          par_d   = 1'b0;
          // The sync MSB goes out now; the remaining bits wait in sync_q.
          out_d   = SYNC_PAT[SYNC_W-1];
          sync_d  = SYNC_PAT << 1;
          valid_d = 1'b1;
          ready_d = 1'b0;
        end
      end

      StSync: begin
        valid_d = 1'b1;
        if (cnt_q == CntW'(SYNC_W - 1)) begin
          state_d = StData;
          cnt_d   = '0;
          out_d   = shreg_q[DATA_W-1];
          par_d   = par_q ^ shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          out_d   = sync_q[SYNC_W-1];
          sync_d  = sync_q << 1;
        end
      end

      StData: begin
        valid_d = 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) begin
          // par_q already covers every payload bit that has been sent.
          state_d = StPar;
          cnt_d   = '0;
          out_d   = par_q;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          out_d   = shreg_q[DATA_W-1];
          par_d   = par_q ^ shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end
      end

      StPar: begin
        cnt_d = '0;
        if (IDLE_BITS > 0) begin
          state_d = StGap;
        end else begin
          state_d = StIdle;
          ready_d = 1'b1;
        end
      end

      StGap: begin
        if (cnt_q == CntW'(IDLE_BITS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      sync_q  <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
      par_q   <= par_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign done_o      = done_q;

endmodule
